// File: rtl/countdown_bar_pkg.sv
// Shared types and constants for the countdown time-bar overlay.
// The VGA bus is a packed struct. Its flat width is VGA_BUS_SIZE bits.
// Field layout, MSB to LSB: hcount, vcount, hsync, vsync, rgb.
package countdown_bar_pkg;

    localparam int unsigned HCOUNT_W     = 11;
    localparam int unsigned VCOUNT_W     = 11;
    localparam int unsigned RGB_W        = 12;
    localparam int unsigned VGA_BUS_SIZE = HCOUNT_W + VCOUNT_W + 2 + RGB_W;

    typedef struct packed {
        logic [HCOUNT_W-1:0] hcount;
        logic [VCOUNT_W-1:0] vcount;
        logic                hsync;
        logic                vsync;
        logic [RGB_W-1:0]    rgb;
    } vga_bus_t;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_ARMED   = 3'd1,
        ST_RUNNING = 3'd2,
        ST_PAUSED  = 3'd3,
        ST_EXPIRED = 3'd4
    } state_t;

    localparam logic [RGB_W-1:0] DEF_FILL_COLOR = 12'h0F0;
    localparam logic [RGB_W-1:0] DEF_BG_COLOR   = 12'h333;
    localparam logic [RGB_W-1:0] DEF_WARN_COLOR = 12'hF00;

    // Counter width for a modulo-n counter. It is never narrower than 1 bit.
    function automatic int unsigned cnt_width(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/countdown_bar_ms_divider.sv
// Millisecond-tick to pixel-step divider.
// o_step pulses on the tick that completes MS_PER_PIXEL counted ticks.
// Ticks are counted only while i_run is high, so a paused bar freezes here.
// i_clear restarts the count from zero.
module countdown_bar_ms_divider
    import countdown_bar_pkg::*;
#(
    parameter int unsigned MS_PER_PIXEL = 40
) (
    input  logic clk,
    input  logic rst_n,
    input  logic i_clear,
    input  logic i_run,
    input  logic i_tick,
    output logic o_step
);

    localparam int unsigned          CNT_W   = cnt_width(MS_PER_PIXEL);
    localparam logic [CNT_W-1:0]     CNT_MAX = CNT_W'(MS_PER_PIXEL - 1);

    logic [CNT_W-1:0] r_ms_cnt;
    logic             w_adv;

    assign w_adv  = i_tick & i_run;
    assign o_step = w_adv & (r_ms_cnt == CNT_MAX);

    // Count gated ticks modulo MS_PER_PIXEL.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_ms_cnt <= '0;
        end else if (i_clear) begin
            r_ms_cnt <= '0;
        end else if (w_adv) begin
            if (r_ms_cnt == CNT_MAX) r_ms_cnt <= '0;
            else                     r_ms_cnt <= r_ms_cnt + 1'b1;
        end
    end

endmodule

// File: rtl/countdown_bar.sv
// Countdown time-bar overlay for the VGA bus.
// The bar loses one pixel every MS_PER_PIXEL ms and supports pause and bonus refill.
// It switches to a blinking warning colour when little time is left.
// Every bus field leaves exactly one clock after it arrives.
// Handshake: this block has no valid/ready channel.
//   start and add_bonus are single-cycle pulses sampled on the clock edge.
//   pause and module_en are levels.
//   one_ms_tick is a one-cycle pulse that advances time.
module countdown_bar
    import countdown_bar_pkg::*;
#(
    parameter int unsigned      BAR_X        = 0,
    parameter int unsigned      BAR_Y        = 575,
    parameter int unsigned      BAR_W        = 800,
    parameter int unsigned      BAR_H        = 25,
    parameter int unsigned      MS_PER_PIXEL = 40,
    parameter int unsigned      WARN_PIXELS  = 160,
    parameter int unsigned      BLINK_MS     = 250,
    parameter int unsigned      BONUS_PIXELS = 100,
    parameter logic [RGB_W-1:0] FILL_COLOR   = DEF_FILL_COLOR,
    parameter logic [RGB_W-1:0] BG_COLOR     = DEF_BG_COLOR,
    parameter logic [RGB_W-1:0] WARN_COLOR   = DEF_WARN_COLOR
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    module_en,
    input  logic                    start,
    input  logic                    pause,
    input  logic                    add_bonus,
    input  logic                    one_ms_tick,
    input  logic [VGA_BUS_SIZE-1:0] vga_bus_in,
    output logic [VGA_BUS_SIZE-1:0] vga_bus_out,
    output logic [9:0]              remaining,
    output logic                    warning,
    output logic                    elapsed,
    output state_t                  state_dbg
);

    localparam logic [9:0]  W_BAR   = 10'(BAR_W);
    localparam logic [10:0] W_BONUS = 11'(BONUS_PIXELS);
    localparam logic [10:0] W_WARN  = 11'(WARN_PIXELS);
    localparam logic [11:0] X_LO    = 12'(BAR_X);
    localparam logic [11:0] X_HI    = 12'(BAR_X + BAR_W);
    localparam logic [11:0] Y_LO    = 12'(BAR_Y);
    localparam logic [11:0] Y_HI    = 12'(BAR_Y + BAR_H);
    localparam int unsigned BLK_W   = cnt_width(BLINK_MS);
    localparam logic [BLK_W-1:0] BLK_MAX = BLK_W'(BLINK_MS - 1);

    vga_bus_t         w_bus_in;
    vga_bus_t         r_bus_out;
    state_t           r_state;
    logic [9:0]       r_remaining;
    logic [BLK_W-1:0] r_blink_cnt;
    logic             r_blink_on;

    logic             w_start_go;
    logic             w_active;
    logic             w_run;
    logic             w_clear;
    logic             w_step;
    logic             w_dec;
    logic             w_bonus;
    logic [10:0]      w_sum;
    logic [9:0]       w_rem_next;
    logic             w_warning;
    logic [11:0]      w_hx;
    logic [11:0]      w_vy;
    logic [11:0]      w_xoff;
    logic             w_in_bar;
    logic [RGB_W-1:0] w_rgb;

    assign w_bus_in = vga_bus_t'(vga_bus_in);

    // A start pulse is honoured in every enabled state except IDLE.
    assign w_start_go = module_en & start & (r_state != ST_IDLE);
    assign w_active   = (r_state == ST_RUNNING) || (r_state == ST_PAUSED);
    // Time advances only in RUNNING, and only when pause, start and disable are all absent.
    assign w_run      = module_en & ~start & ~pause & (r_state == ST_RUNNING);
    assign w_clear    = w_start_go | ~module_en;

    countdown_bar_ms_divider #(
        .MS_PER_PIXEL(MS_PER_PIXEL)
    ) u_ms_divider (
        .clk    (clk),
        .rst_n  (rst_n),
        .i_clear(w_clear),
        .i_run  (w_run),
        .i_tick (one_ms_tick),
        .o_step (w_step)
    );

    // Decrement and bonus are summed in 11 bits, then saturated at BAR_W.
    // The decrement is suppressed at zero so the length never wraps.
    assign w_dec      = w_step & (r_remaining != 10'd0);
    assign w_bonus    = module_en & ~start & add_bonus & w_active;
    assign w_sum      = {1'b0, r_remaining} - {10'd0, w_dec} + (w_bonus ? W_BONUS : 11'd0);
    assign w_rem_next = (w_sum > {1'b0, W_BAR}) ? W_BAR : w_sum[9:0];
    assign w_warning  = w_active && ({1'b0, r_remaining} <= W_WARN);

    // Main FSM and remaining-length register. Disable overrides everything.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= ST_IDLE;
            r_remaining <= 10'd0;
        end else if (!module_en) begin
            r_state     <= ST_IDLE;
            r_remaining <= 10'd0;
        end else if (w_start_go) begin
            r_state     <= pause ? ST_PAUSED : ST_RUNNING;
            r_remaining <= W_BAR;
        end else begin
            case (r_state)
                ST_IDLE:    r_state <= ST_ARMED;
                ST_ARMED:   r_state <= ST_ARMED;
                ST_RUNNING: begin
                    r_remaining <= w_rem_next;
                    if ((r_remaining == 10'd0) && !w_bonus) r_state <= ST_EXPIRED;
                    else if (pause)                         r_state <= ST_PAUSED;
                end
                ST_PAUSED: begin
                    r_remaining <= w_rem_next;
                    if (!pause) r_state <= ST_RUNNING;
                end
                ST_EXPIRED: r_state <= ST_EXPIRED;
                default:    r_state <= ST_IDLE;
            endcase
        end
    end

    // Warning blink. It counts running ticks while in warning and toggles at each wrap.
    // It re-arms to on whenever warning is low.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_blink_cnt <= '0;
            r_blink_on  <= 1'b1;
        end else if (w_start_go || !w_warning || !module_en) begin
            r_blink_cnt <= '0;
            r_blink_on  <= 1'b1;
        end else if (one_ms_tick && w_run) begin
            if (r_blink_cnt == BLK_MAX) begin
                r_blink_cnt <= '0;
                r_blink_on  <= ~r_blink_on;
            end else begin
                r_blink_cnt <= r_blink_cnt + 1'b1;
            end
        end
    end

    assign w_hx     = {1'b0, w_bus_in.hcount};
    assign w_vy     = {1'b0, w_bus_in.vcount};
    assign w_xoff   = w_hx - X_LO;
    assign w_in_bar = (w_hx >= X_LO) && (w_hx < X_HI) && (w_vy >= Y_LO) && (w_vy < Y_HI);

    // Pixel colour inside the bar rectangle, chosen by state. Outside the bar, rgb passes through.
    always_comb begin
        w_rgb = w_bus_in.rgb;
        if (w_in_bar) begin
            case (r_state)
                ST_ARMED:   w_rgb = FILL_COLOR;
                ST_RUNNING,
                ST_PAUSED: begin
                    if (w_xoff < {2'b00, r_remaining}) begin
                        if (!w_warning)      w_rgb = FILL_COLOR;
                        else if (r_blink_on) w_rgb = WARN_COLOR;
                        else                 w_rgb = BG_COLOR;
                    end else begin
                        w_rgb = BG_COLOR;
                    end
                end
                ST_EXPIRED: w_rgb = BG_COLOR;
                default:    w_rgb = w_bus_in.rgb;
            endcase
        end
    end

    // One-clock bus register carrying timing fields unchanged and the overlaid rgb.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_bus_out <= '0;
        end else begin
            r_bus_out     <= w_bus_in;
            r_bus_out.rgb <= w_rgb;
        end
    end

    assign vga_bus_out = r_bus_out;
    assign remaining   = r_remaining;
    assign warning     = w_warning;
    assign elapsed     = (r_state == ST_EXPIRED);
    assign state_dbg   = r_state;

endmodule

// File: tb/tb_countdown_bar.sv
// Directed bench for countdown_bar, built with a small test geometry.
// The bar starts at x=10, y=20 and is 16 pixels wide and 2 lines tall.
// One pixel takes 4 ticks; warning is at 4 pixels; bonus adds 5; blink half-period is 2 ms.
module tb_countdown_bar;
    import countdown_bar_pkg::*;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic                    rst_n;
    logic                    module_en;
    logic                    start;
    logic                    pause;
    logic                    add_bonus;
    logic                    one_ms_tick;
    vga_bus_t                bus_in;
    logic [VGA_BUS_SIZE-1:0] bus_out_raw;
    vga_bus_t                bus_out;
    logic [9:0]              remaining;
    logic                    warning;
    logic                    elapsed;
    state_t                  state_dbg;

    int n_vec = 0;
    int n_err = 0;

    assign bus_out = vga_bus_t'(bus_out_raw);

    countdown_bar #(
        .BAR_X(10), .BAR_Y(20), .BAR_W(16), .BAR_H(2),
        .MS_PER_PIXEL(4), .WARN_PIXELS(4), .BLINK_MS(2), .BONUS_PIXELS(5)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .module_en  (module_en),
        .start      (start),
        .pause      (pause),
        .add_bonus  (add_bonus),
        .one_ms_tick(one_ms_tick),
        .vga_bus_in (bus_in),
        .vga_bus_out(bus_out_raw),
        .remaining  (remaining),
        .warning    (warning),
        .elapsed    (elapsed),
        .state_dbg  (state_dbg)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [35:0] obs, input logic [35:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        one_ms_tick = 1'b1;
        step();
        one_ms_tick = 1'b0;
        step();
    endtask

    task automatic ticks(input int n);
        for (int k = 0; k < n; k++) tick();
    endtask

    task automatic pulse_start();
        start = 1'b1;
        step();
        start = 1'b0;
    endtask

    task automatic pix(input string tag, input logic [10:0] x, input logic [10:0] y,
                       input logic [11:0] exp);
        bus_in.hcount = x;
        bus_in.vcount = y;
        bus_in.rgb    = 12'hABC;
        step();
        chk(tag, {24'd0, bus_out.rgb}, {24'd0, exp});
    endtask

    initial begin
        rst_n = 1'b0; module_en = 1'b0; start = 1'b0; pause = 1'b0;
        add_bonus = 1'b0; one_ms_tick = 1'b0; bus_in = '0;
        step(); step();
        rst_n = 1'b1;
        step();

        // 1: asynchronous reset in the middle of a run
        module_en = 1'b1;
        step();
        pulse_start();
        ticks(5);
        bus_in.hcount = 11'd12; bus_in.vcount = 11'd20; bus_in.hsync = 1'b1; bus_in.rgb = 12'h555;
        step();
        #2 rst_n = 1'b0;
        #1;
        chk("rst_bus", bus_out_raw, 36'd0);
        chk("rst_rem", remaining, 10'd0);
        chk("rst_warn", warning, 1'b0);
        chk("rst_elapsed", elapsed, 1'b0);
        chk("rst_state", state_dbg, ST_IDLE);
        module_en = 1'b0;
        step();
        rst_n = 1'b1;
        bus_in.hcount = 11'd5; bus_in.vcount = 11'd7; bus_in.hsync = 1'b1;
        bus_in.vsync = 1'b0; bus_in.rgb = 12'h123;
        step();
        chk("pass_bus", bus_out_raw, {11'd5, 11'd7, 1'b1, 1'b0, 12'h123});
        bus_in.rgb = 12'h456;
        #1;
        chk("pass_latency", {24'd0, bus_out.rgb}, {24'd0, 12'h123});
        bus_in.hsync = 1'b0;
        pix("idle_in_bar", 11'd12, 11'd20, 12'hABC);

        // 2: full countdown to expiry
        module_en = 1'b1;
        step();
        chk("armed_state", state_dbg, ST_ARMED);
        pix("armed_x_lo", 11'd10, 11'd20, 12'h0F0);
        pix("armed_x_hi", 11'd25, 11'd21, 12'h0F0);
        pix("armed_x_out", 11'd26, 11'd21, 12'hABC);
        pix("armed_y_out", 11'd12, 11'd22, 12'hABC);
        pix("armed_x_left", 11'd9, 11'd20, 12'hABC);
        pulse_start();
        chk("start_rem", remaining, 10'd16);
        chk("start_state", state_dbg, ST_RUNNING);
        for (int i = 1; i <= 63; i++) begin
            tick();
            chk($sformatf("count_rem_%0d", i), remaining, 10'(16 - i / 4));
        end
        one_ms_tick = 1'b1;
        step();
        one_ms_tick = 1'b0;
        chk("zero_rem", remaining, 10'd0);
        chk("zero_not_elapsed", elapsed, 1'b0);
        step();
        chk("expired_elapsed", elapsed, 1'b1);
        chk("expired_state", state_dbg, ST_EXPIRED);
        pix("expired_pix", 11'd10, 11'd20, 12'h333);
        add_bonus = 1'b1;
        step();
        add_bonus = 1'b0;
        chk("expired_bonus_ign", remaining, 10'd0);

        // 3: pause freezes the countdown
        pulse_start();
        chk("restart_elapsed", elapsed, 1'b0);
        ticks(10);
        chk("pre_pause_rem", remaining, 10'd14);
        pause = 1'b1;
        step();
        chk("paused_state", state_dbg, ST_PAUSED);
        ticks(20);
        chk("paused_rem", remaining, 10'd14);
        pause = 1'b0;
        step();
        chk("resume_state", state_dbg, ST_RUNNING);
        ticks(2);
        chk("resume_rem", remaining, 10'd13);

        // 4: bonus saturates at the bar width; bonus coinciding with a decrement
        pulse_start();
        ticks(10);
        chk("bonus_pre", remaining, 10'd14);
        add_bonus = 1'b1;
        step();
        add_bonus = 1'b0;
        chk("bonus_sat", remaining, 10'd16);
        ticks(53);
        chk("bonus_pre3", remaining, 10'd3);
        chk("warn_at3", warning, 1'b1);
        one_ms_tick = 1'b1; add_bonus = 1'b1;
        step();
        one_ms_tick = 1'b0; add_bonus = 1'b0;
        chk("bonus_dec", remaining, 10'd7);
        chk("warn_off7", warning, 1'b0);

        // 5: warning threshold, warning colour and blink
        pulse_start();
        ticks(47);
        chk("rem5", remaining, 10'd5);
        chk("warn_at5", warning, 1'b0);
        tick();
        chk("rem4", remaining, 10'd4);
        chk("warn_at4", warning, 1'b1);
        pix("warn_x10", 11'd10, 11'd20, 12'hF00);
        pix("warn_x13", 11'd13, 11'd21, 12'hF00);
        pix("warn_x14", 11'd14, 11'd20, 12'h333);
        ticks(2);
        chk("blink_rem", remaining, 10'd4);
        pix("blink_off_x10", 11'd10, 11'd20, 12'h333);

        // 6: disable while paused
        pause = 1'b1;
        step();
        chk("p6_paused", state_dbg, ST_PAUSED);
        module_en = 1'b0;
        step();
        chk("dis_state", state_dbg, ST_IDLE);
        chk("dis_elapsed", elapsed, 1'b0);
        chk("dis_warn", warning, 1'b0);
        pix("dis_pass", 11'd12, 11'd21, 12'hABC);
        pause = 1'b0;
        add_bonus = 1'b1;
        step();
        add_bonus = 1'b0;
        chk("idle_bonus_ign", remaining, 10'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
